// File: rtl/laser_search_param.sv
// Places one or two circles on a 2^COORD_W grid to cover the most points of a loaded frame.
// Latency: P*(G*G*NPTS/LANES+1)+2 cycles from last accept to DONE; IN_READY low from search start to DONE.
module laser_search_param #(
   parameter int COORD_W   = 4,
   parameter int NPTS      = 40,
   parameter int LANES     = 4,
   parameter int RADIUS_SQ = 16,
   parameter int MAX_ITER  = 4,
   parameter int CNT_W     = $clog2(NPTS+1)
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_mode,
   input  logic               i_in_valid,
   input  logic [COORD_W-1:0] i_x,
   input  logic [COORD_W-1:0] i_y,
   output logic               o_in_ready,
   output logic [COORD_W-1:0] o_c1x,
   output logic [COORD_W-1:0] o_c1y,
   output logic [COORD_W-1:0] o_c2x,
   output logic [COORD_W-1:0] o_c2y,
   output logic [CNT_W-1:0]   o_cover,
   output logic               o_done
);
   localparam int CHUNKS = NPTS / LANES;
   localparam int CH_W   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam int IDX_W  = (NPTS > 1) ? $clog2(NPTS) : 1;
   localparam int IT_W   = $clog2(MAX_ITER + 1);
   localparam logic [COORD_W-1:0] L_CMAX = '1;
   localparam logic [2*COORD_W:0] L_RSQ  = (2*COORD_W+1)'(RADIUS_SQ);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PASS1, S_PASS2, S_FINISH} state_t;

   state_t             r_state;
   logic [COORD_W-1:0] r_px [NPTS];
   logic [COORD_W-1:0] r_py [NPTS];
   logic [IDX_W-1:0]   r_cnt;
   logic               r_mode;
   logic [COORD_W-1:0] r_cx, r_cy, r_bx, r_by;
   logic [CH_W-1:0]    r_chunk;
   logic [CNT_W-1:0]   r_acc, r_best, r_prev, r_cover;
   logic               r_best_vld, r_commit, r_c2_vld;
   logic [COORD_W-1:0] r_c1x, r_c1y, r_c2x, r_c2y;
   logic [IT_W-1:0]    r_iter;
   logic               r_in_ready, r_done;
   logic [COORD_W-1:0] r_o_c1x, r_o_c1y, r_o_c2x, r_o_c2y;
   logic [CNT_W-1:0]   r_o_cover;

   logic               w_oth_vld;
   logic [COORD_W-1:0] w_ox, w_oy;
   logic [LANES-1:0]   w_hit;
   logic [CNT_W-1:0]   w_lane_sum, w_total;
   logic               w_last_chunk, w_better;

   // |dx| equals the magnitude of the signed COORD_W+1-bit difference; the sum cannot overflow.
   function automatic logic in_circ(input logic [COORD_W-1:0] ax, input logic [COORD_W-1:0] ay,
                                    input logic [COORD_W-1:0] bx, input logic [COORD_W-1:0] by);
      logic [COORD_W-1:0]   adx, ady;
      logic [2*COORD_W-1:0] sx, sy;
      logic [2*COORD_W:0]   d;
      adx = (ax >= bx) ? ax - bx : bx - ax;
      ady = (ay >= by) ? ay - by : by - ay;
      sx  = {{COORD_W{1'b0}}, adx} * {{COORD_W{1'b0}}, adx};
      sy  = {{COORD_W{1'b0}}, ady} * {{COORD_W{1'b0}}, ady};
      d   = {1'b0, sx} + {1'b0, sy};
      return d <= L_RSQ;
   endfunction

   // PASS1 sees no other circle until the first PASS2 has committed C2.
   assign w_oth_vld = (r_state == S_PASS2) | r_c2_vld;
   assign w_ox      = (r_state == S_PASS2) ? r_c1x : r_c2x;
   assign w_oy      = (r_state == S_PASS2) ? r_c1y : r_c2y;

   always_comb begin : lanes
      logic [IDX_W-1:0] idx;
      w_hit      = '0;
      w_lane_sum = '0;
      idx        = '0;
      for (int l = 0; l < LANES; l++) begin
         idx = IDX_W'(r_chunk) * IDX_W'(LANES) + IDX_W'(l);
         w_hit[l] = in_circ(r_px[idx], r_py[idx], r_cx, r_cy) |
                    (w_oth_vld & in_circ(r_px[idx], r_py[idx], w_ox, w_oy));
         w_lane_sum = w_lane_sum + {{(CNT_W-1){1'b0}}, w_hit[l]};
      end
   end

   assign w_total      = r_acc + w_lane_sum;
   assign w_last_chunk = (r_chunk == CH_W'(CHUNKS - 1));
   assign w_better     = !r_best_vld || (w_total > r_best);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         for (int i = 0; i < NPTS; i++) begin
            r_px[i] <= '0;
            r_py[i] <= '0;
         end
         r_cnt      <= '0;
         r_mode     <= 1'b0;
         r_cx       <= '0;
         r_cy       <= '0;
         r_bx       <= '0;
         r_by       <= '0;
         r_chunk    <= '0;
         r_acc      <= '0;
         r_best     <= '0;
         r_prev     <= '0;
         r_cover    <= '0;
         r_best_vld <= 1'b0;
         r_commit   <= 1'b0;
         r_c2_vld   <= 1'b0;
         r_c1x      <= '0;
         r_c1y      <= '0;
         r_c2x      <= '0;
         r_c2y      <= '0;
         r_iter     <= '0;
         r_in_ready <= 1'b1;
         r_done     <= 1'b0;
         r_o_c1x    <= '0;
         r_o_c1y    <= '0;
         r_o_c2x    <= '0;
         r_o_c2y    <= '0;
         r_o_cover  <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE, S_LOAD: begin
               if (i_in_valid) begin
                  r_px[r_cnt] <= i_x;
                  r_py[r_cnt] <= i_y;
                  if (r_state == S_IDLE) r_mode <= i_mode;
                  if (r_cnt == IDX_W'(NPTS - 1)) begin
                     r_cnt      <= '0;
                     r_state    <= S_PASS1;
                     r_in_ready <= 1'b0;
                     r_cx       <= '0;
                     r_cy       <= '0;
                     r_chunk    <= '0;
                     r_acc      <= '0;
                     r_best_vld <= 1'b0;
                     r_commit   <= 1'b0;
                     r_c2_vld   <= 1'b0;
                     r_iter     <= '0;
                     r_prev     <= '0;
                  end else begin
                     r_cnt   <= r_cnt + IDX_W'(1);
                     r_state <= S_LOAD;
                  end
               end
            end
            S_PASS1, S_PASS2: begin
               if (r_commit) begin
                  r_commit   <= 1'b0;
                  r_best_vld <= 1'b0;
                  if (r_state == S_PASS1) begin
                     r_c1x <= r_bx;
                     r_c1y <= r_by;
                     if (r_mode) begin
                        r_c2x   <= r_bx;
                        r_c2y   <= r_by;
                        r_cover <= r_best;
                        r_state <= S_FINISH;
                     end else begin
                        r_state <= S_PASS2;
                     end
                  end else begin
                     r_c2x    <= r_bx;
                     r_c2y    <= r_by;
                     r_c2_vld <= 1'b1;
                     r_cover  <= r_best;
                     r_prev   <= r_best;
                     r_iter   <= r_iter + IT_W'(1);
                     if (r_best <= r_prev || r_iter == IT_W'(MAX_ITER - 1))
                        r_state <= S_FINISH;
                     else
                        r_state <= S_PASS1;
                  end
               end else if (w_last_chunk) begin
                  r_chunk <= '0;
                  r_acc   <= '0;
                  if (w_better) begin
                     r_best     <= w_total;
                     r_best_vld <= 1'b1;
                     r_bx       <= r_cx;
                     r_by       <= r_cy;
                  end
                  if (r_cx == L_CMAX) begin
                     r_cx <= '0;
                     if (r_cy == L_CMAX) begin
                        r_cy     <= '0;
                        r_commit <= 1'b1;
                     end else begin
                        r_cy <= r_cy + COORD_W'(1);
                     end
                  end else begin
                     r_cx <= r_cx + COORD_W'(1);
                  end
               end else begin
                  r_chunk <= r_chunk + CH_W'(1);
                  r_acc   <= w_total;
               end
            end
            S_FINISH: begin
               r_o_c1x    <= r_c1x;
               r_o_c1y    <= r_c1y;
               r_o_c2x    <= r_c2x;
               r_o_c2y    <= r_c2y;
               r_o_cover  <= r_cover;
               r_done     <= 1'b1;
               r_in_ready <= 1'b1;
               r_state    <= S_IDLE;
            end
            default: begin
               r_state    <= S_IDLE;
               r_in_ready <= 1'b1;
            end
         endcase
      end
   end

   assign o_in_ready = r_in_ready;
   assign o_c1x      = r_o_c1x;
   assign o_c1y      = r_o_c1y;
   assign o_c2x      = r_o_c2x;
   assign o_c2y      = r_o_c2y;
   assign o_cover    = r_o_cover;
   assign o_done     = r_done;
endmodule

// File: tb/tb_laser_search_param.sv
// Scoreboard bench: each frame pushes its expected result; per-DUT monitors pop and compare on DONE.
module tb_laser_search_param;
   localparam int PASS_CYC = 16 * 16 * 10 + 1;

   typedef struct {
      int c1x, c1y, c2x, c2y, cov, lat;
   } exp_t;

   logic       clk, rst0, rst1, mode, in_valid;
   logic [3:0] in_x, in_y;
   logic       rdy0, rdy1, done0, done1;
   logic [3:0] c1x0, c1y0, c2x0, c2y0, c1x1, c1y1, c2x1, c2y1;
   logic [5:0] cov0, cov1;

   int   n_tests = 0, n_fail = 0, cyc = 0, last_acc = 0;
   bit   sel = 0, prev_done0 = 0, prev_done1 = 0;
   exp_t q0[$], q1[$];
   exp_t e0, e1, tmp;

   laser_search_param u_dut0 (
      .i_clk(clk), .i_rst(rst0), .i_mode(mode), .i_in_valid(in_valid), .i_x(in_x), .i_y(in_y),
      .o_in_ready(rdy0), .o_c1x(c1x0), .o_c1y(c1y0), .o_c2x(c2x0), .o_c2y(c2y0),
      .o_cover(cov0), .o_done(done0));

   laser_search_param #(.MAX_ITER(1)) u_dut1 (
      .i_clk(clk), .i_rst(rst1), .i_mode(mode), .i_in_valid(in_valid), .i_x(in_x), .i_y(in_y),
      .o_in_ready(rdy1), .o_c1x(c1x1), .o_c1y(c1y1), .o_c2x(c2x1), .o_c2y(c2y1),
      .o_cover(cov1), .o_done(done1));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cmp_res(input string tag, input exp_t e, input int ax, input int ay,
                          input int bx, input int by, input int cv, input int lat);
      check({tag, "_c1x"}, ax, e.c1x);
      check({tag, "_c1y"}, ay, e.c1y);
      check({tag, "_c2x"}, bx, e.c2x);
      check({tag, "_c2y"}, by, e.c2y);
      check({tag, "_cover"}, cv, e.cov);
      check({tag, "_latency"}, lat, e.lat);
   endtask

   always @(negedge clk) begin
      if (prev_done0) check("done0_width", int'(done0), 0);
      if (done0) begin
         if (q0.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL spurious_done0: DONE seen with no frame outstanding");
         end else begin
            e0 = q0.pop_front();
            cmp_res("dut0", e0, c1x0, c1y0, c2x0, c2y0, cov0, cyc - last_acc);
         end
      end
      prev_done0 = done0;
   end

   always @(negedge clk) begin
      if (prev_done1) check("done1_width", int'(done1), 0);
      if (done1) begin
         if (q1.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL spurious_done1: DONE seen with no frame outstanding");
         end else begin
            e1 = q1.pop_front();
            cmp_res("dut1", e1, c1x1, c1y1, c2x1, c2y1, cov1, cyc - last_acc);
         end
      end
      prev_done1 = done1;
   end

   task automatic push(input bit which, input int ax, input int ay, input int bx, input int by,
                       input int cv, input int passes);
      tmp.c1x = ax; tmp.c1y = ay; tmp.c2x = bx; tmp.c2y = by; tmp.cov = cv;
      tmp.lat = passes * PASS_CYC + 2;
      if (which) q1.push_back(tmp);
      else       q0.push_back(tmp);
   endtask

   // pat 0: all points at (8,8); pat 1: 20 at (2,2) then 20 at (13,13)
   task automatic send_frame(input int pat, input logic m, input bit gaps);
      int i = 0;
      int guard = 0;
      while (i < 40 && guard < 2000) begin
         @(negedge clk);
         guard++;
         if (!gaps || $urandom_range(0, 1) == 1) begin
            in_valid = 1'b1;
            mode     = m;
            in_x     = (pat == 0) ? 4'd8 : ((i < 20) ? 4'd2 : 4'd13);
            in_y     = in_x;
            if (sel ? rdy1 : rdy0) begin
               last_acc = cyc;
               i++;
            end
         end else begin
            in_valid = 1'b0;
            in_x     = 4'd15;
         end
      end
      if (i < 40) begin
         n_tests++;
         n_fail++;
         $display("FAIL load_timeout: accepted %0d of 40 points", i);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Optionally floods junk valid points while searching; they must be ignored.
   task automatic wait_done(input int budget, input bit junk);
      int  n = 0;
      int  bad = 0;
      bit  seen = 0;
      if (junk) begin
         in_valid = 1'b1;
         in_x     = 4'd15;
         in_y     = 4'd0;
      end
      while (!seen && n < budget) begin
         @(negedge clk);
         n++;
         if (sel ? done1 : done0) begin
            seen     = 1;
            in_valid = 1'b0;
         end else if (sel ? rdy1 : rdy0) begin
            bad++;
         end
      end
      in_valid = 1'b0;
      if (!seen) begin
         n_tests++;
         n_fail++;
         $display("FAIL done_timeout: no DONE within %0d cycles", budget);
      end
      check("ready_low_in_search", bad, 0);
   endtask

   initial begin
      rst0 = 1'b1; rst1 = 1'b1; mode = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0;
      repeat (2) @(negedge clk);
      check("rst_ready", int'(rdy0), 1);
      check("rst_done", int'(done0), 0);
      check("rst_cover", int'(cov0), 0);
      check("rst_c1x", int'(c1x0), 0);
      rst0 = 1'b0;
      @(negedge clk);

      // single cluster, two circles: four passes
      push(0, 8, 4, 0, 0, 40, 4);
      send_frame(0, 1'b0, 0);
      wait_done(4 * PASS_CYC + 50, 0);

      // two clusters, two circles, junk valid during the search
      push(0, 0, 0, 13, 9, 40, 4);
      send_frame(1, 1'b0, 0);
      wait_done(4 * PASS_CYC + 50, 1);

      // abort mid PASS2 with reset, then single-circle frame
      send_frame(1, 1'b0, 0);
      repeat (PASS_CYC + 1000) @(negedge clk);
      rst0 = 1'b1;
      @(negedge clk);
      check("abort_ready", int'(rdy0), 1);
      check("abort_c2x", int'(c2x0), 0);
      check("abort_c2y", int'(c2y0), 0);
      check("abort_cover", int'(cov0), 0);
      check("abort_done", int'(done0), 0);
      repeat (3) @(negedge clk);
      rst0 = 1'b0;
      repeat (20) @(negedge clk);
      check("abort_no_done", q0.size(), 0);
      push(0, 8, 4, 8, 4, 40, 1);
      send_frame(0, 1'b1, 0);
      wait_done(PASS_CYC + 50, 0);

      // two clusters, single circle
      push(0, 0, 0, 0, 0, 20, 1);
      send_frame(1, 1'b1, 0);
      wait_done(PASS_CYC + 50, 0);

      // valid gaps during load, then back-to-back frame without reset
      push(0, 0, 0, 13, 9, 40, 4);
      send_frame(1, 1'b0, 1);
      wait_done(4 * PASS_CYC + 50, 0);
      push(0, 0, 0, 0, 0, 20, 1);
      send_frame(1, 1'b1, 1);
      wait_done(PASS_CYC + 50, 0);

      // MAX_ITER=1 instance: stops after the first pass pair
      rst0 = 1'b1;
      rst1 = 1'b0;
      sel  = 1;
      @(negedge clk);
      push(1, 0, 0, 13, 9, 40, 2);
      send_frame(1, 1'b0, 0);
      wait_done(2 * PASS_CYC + 50, 0);

      repeat (3) @(negedge clk);
      check("q0_drained", q0.size(), 0);
      check("q1_drained", q1.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/laser_search_param.md
Name: laser_search_param

Overview:
- Parametrised successor to the fixed 40-point, 16x16, two-circle LASER engine.
- Accepts a frame of NPTS points over a valid handshake and places one or two circles of squared radius RADIUS_SQ to maximise covered points.
- Uses alternating exhaustive grid scans with LANES points evaluated per cycle.
- Returns to IDLE after each result, so back-to-back frames need no reset.

Parameters:
- COORD_W, 4, coordinate width; grid is 2^COORD_W x 2^COORD_W
- NPTS, 40, points per frame; must be divisible by LANES
- LANES, 4, points evaluated in parallel per cycle
- RADIUS_SQ, 16, point covered iff squared distance <= RADIUS_SQ
- MAX_ITER, 4, maximum C1/C2 pass pairs per frame (>=1)
- CNT_W, $clog2(NPTS+1), coverage counter width

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- MODE  in  1  sampled on first accepted point; 0 = two circles, 1 = single circle
- IN_VALID  in  1  X/Y hold a valid point this cycle
- X  in  COORD_W  point x
- Y  in  COORD_W  point y
- IN_READY  out  1  high in IDLE/LOAD; point accepted when IN_VALID && IN_READY
- C1X, C1Y  out  COORD_W  circle 1 centre
- C2X, C2Y  out  COORD_W  circle 2 centre
- COVER  out  CNT_W  points covered by union of circles
- DONE  out  1  one-cycle pulse; outputs valid from this cycle

Behaviour:
- Clock/reset: one clock CLK; RST is asynchronous, active-high.
- Reset:
  - State IDLE; all outputs 0 except IN_READY = 1.
  - Point buffer and search registers are cleared.
  - RST asserted mid-frame or mid-search aborts, with no DONE.
- States: IDLE -> LOAD -> PASS1 -> PASS2 -> (PASS1 | FINISH) -> IDLE.
- IDLE / LOAD:
  - Each accepted point is stored at index cnt; cnt increments.
  - IN_VALID gaps are allowed.
  - The NPTS-th accept moves to PASS1 next cycle; IN_READY drops the same cycle.
  - IN_VALID outside IDLE/LOAD is ignored.
- Pass:
  - Scans candidates y outer 0..max, x inner 0..max.
  - Each candidate takes NPTS/LANES cycles; LANES points per cycle, count accumulated.
  - Point counts if inside the candidate OR inside the other circle (union).
  - Before the first PASS2 completes, the other circle of PASS1 is "none" (covers nothing).
  - best starts at -1 each pass. Update only on strictly greater count, so the first candidate in scan order wins ties.
  - At pass end, the winner is committed to C1 (PASS1) or C2 (PASS2) internal regs; 1 commit cycle.
- Arithmetic:
  - dx, dy are signed COORD_W+1-bit differences.
  - dx^2 + dy^2 uses 2*COORD_W+1 bits, unsigned compare <= RADIUS_SQ, no overflow.
- Iteration:
  - After each PASS2 commit: iter++.
  - Go to FINISH if union cover did not strictly exceed the previous pair's cover (initially 0) or iter == MAX_ITER; else PASS1.
- MODE = 1: PASS2 is skipped; C2 := C1; FINISH directly after the first PASS1.
- FINISH:
  - Drives C1X/C1Y/C2X/C2Y/COVER from internal regs and pulses DONE for 1 cycle, then IDLE.
  - Outputs hold until the next DONE or RST.
- Latency: last accept -> DONE = P*(G*G*NPTS/LANES + 1) + 2 cycles, with P = passes run and G = 2^COORD_W.

Test Plan:
- Defaults, MODE=0, all 40 points at (8,8) -> 4 passes; DONE with C1=(8,4), C2=(0,0), COVER=40; DONE width 1 cycle.
- Defaults, MODE=0, 20 points at (2,2) + 20 at (13,13) -> C1=(0,0), C2=(13,9), COVER=40; DONE at 4*2561+2 cycles after last accept.
- Defaults, MODE=1, same two clusters -> C1=C2=(0,0), COVER=20; 1 pass.
- Random IN_VALID gaps (50% duty) during load, then a second frame immediately after DONE without RST -> results identical to the gap-free run; IN_READY low from PASS1 until IDLE.
- RST asserted mid-PASS2, then 40 points at (8,8) MODE=1 -> outputs 0 during reset, no spurious DONE, second frame gives C1=C2=(8,4), COVER=40.
- MAX_ITER=1, two clusters, MODE=0 -> FINISH after first PASS2: C1=(0,0), C2=(13,9), COVER=40, total 2 passes.
